// File: rtl/fetch_queue.sv
// Prefetching instruction fetch unit: issues sequential imem reads ahead of the core and
// buffers returned instructions with their PCs in a ready/valid queue, flushed on redirect.
module fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                IMEM_AW  = 14,
    parameter int                DEPTH    = 4,
    parameter int                LAT      = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rstn,
    output logic [IMEM_AW-1:0]         a_inst,
    input  logic [31:0]                d_inst,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int OCC_W = CW + 2;

    logic [ADDR_W-1:0] fpc;
    logic [LAT-1:0]    pv;
    logic [ADDR_W-1:0] ppc [LAT];

    logic [31:0]       q_inst [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    logic [OCC_W-1:0]  inflight;
    logic [OCC_W-1:0]  occupancy;
    logic              issue;
    logic              enq;
    logic              deq;

    // Credit is taken from registered occupancy only, so the queue can never overflow.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + {{(OCC_W-1){1'b0}}, pv[i]};
        end
        occupancy = {{(OCC_W-CW){1'b0}}, count} + inflight;
        issue     = rstn && !redirect && (occupancy < OCC_W'(DEPTH));
        enq       = pv[LAT-1];
        deq       = out_valid && out_ready;
    end

    assign a_inst    = fpc[IMEM_AW+1:2];
    assign out_valid = (count != '0);
    assign out_inst  = q_inst[head];
    assign out_pc    = q_pc[head];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fpc   <= RESET_PC & ~ADDR_W'(3);
            pv    <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < LAT; i++) begin
                ppc[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else if (redirect) begin
            // Everything queued or in flight is stale; a same-cycle handshake is simply dropped.
            fpc   <= redirect_pc & ~ADDR_W'(3);
            pv    <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            pv[0]  <= issue;
            ppc[0] <= fpc;
            for (int i = 1; i < LAT; i++) begin
                pv[i]  <= pv[i-1];
                ppc[i] <= ppc[i-1];
            end
            if (issue) begin
                fpc <= fpc + ADDR_W'(4);
            end
            if (enq) begin
                q_inst[tail] <= d_inst;
                q_pc[tail]   <= ppc[LAT-1];
                tail         <= tail + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
